// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types for the LCD text buffer: key event kinds, the
//               controller state encoding and the blank character code.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Key event kinds carried on key_cmd
  typedef enum logic [1:0] {
    CMD_CHAR      = 2'd0,
    CMD_BACKSPACE = 2'd1,
    CMD_ENTER     = 2'd2,
    CMD_CLEAR     = 2'd3
  } key_cmd_e;

  // Controller states; key events are only taken in ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_ALL  = 2'd1,
    ST_CLR_LINE = 2'd2
  } state_e;

  // Character written into every blanked cell
  localparam logic [7:0] SPACE_CHAR = 8'h20;

endpackage
`default_nettype wire

// File: rtl/lcd_text_buffer_char_ram.sv
`default_nettype none
// ============================================================================
// Module      : char_ram
// Description : Character store, one write port and one registered read
//               port. A same-cycle read and write of one cell returns the
//               value held before the write.
// Revision    : 1.0 - initial release
// ============================================================================
module char_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Array lookup feeding the read register
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  // Storage array: contents are not reset, the controller blanks them
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read data, zero while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/lcd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_text_buffer
// Description : Text buffer for a character LCD. Accepts key events, keeps
//               a cursor, scrolls by rotating the physical row at the top of
//               the screen and blanks cells one per cycle when clearing.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int LINES  = 2,
  parameter int COLS   = 16,
  parameter int CHAR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_valid,
  input  logic [1:0]                 key_cmd,
  input  logic [CHAR_W-1:0]          key_char,
  output logic                       key_ready,
  input  logic [$clog2(LINES)-1:0]   rd_line,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  output logic [CHAR_W-1:0]          rd_data,
  output logic [$clog2(LINES)-1:0]   cur_line,
  output logic [$clog2(COLS)-1:0]    cur_col,
  output logic                       update
);

  localparam int LW = $clog2(LINES);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(LINES * COLS);
  localparam logic [LW:0]       LINES_EXT  = (LW + 1)'(LINES);
  localparam logic [LW-1:0]     LAST_LINE  = LW'(LINES - 1);
  localparam logic [CW-1:0]     LAST_COL   = CW'(COLS - 1);
  localparam logic [AW-1:0]     LAST_CELL  = AW'(LINES * COLS - 1);
  localparam logic [AW-1:0]     LAST_LCNT  = AW'(COLS - 1);
  localparam logic [CHAR_W-1:0] BLANK      = CHAR_W'(SPACE_CHAR);

  // Logical line to physical row, modulo LINES
  function automatic logic [LW-1:0] phys_row(input logic [LW-1:0] t,
                                             input logic [LW-1:0] l);
    logic [LW:0] s;
    s = {1'b0, t} + {1'b0, l};
    if (s >= LINES_EXT) begin
      s = s - LINES_EXT;
    end
    return s[LW-1:0];
  endfunction

  // Physical row/column to flat cell index
  function automatic logic [AW-1:0] cell_addr(input logic [LW-1:0] row,
                                              input logic [CW-1:0] col);
    return AW'(32'(row) * COLS + 32'(col));
  endfunction

  state_e          state_q, state_d;
  logic [LW-1:0]   top_q, top_d;
  logic [LW-1:0]   cur_line_q, cur_line_d;
  logic [CW-1:0]   cur_col_q, cur_col_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            update_q, update_d;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic [AW-1:0]   rd_addr;
  logic [LW-1:0]   top_next;

  assign top_next = (top_q == LAST_LINE) ? '0 : top_q + LW'(1);
  assign rd_addr  = cell_addr(phys_row(top_q, rd_line), rd_col);

  // Key handling, scrolling and clear sequencing
  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    cur_line_d = cur_line_q;
    cur_col_d  = cur_col_q;
    clr_cnt_d  = clr_cnt_q;
    update_d   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = cell_addr(phys_row(top_q, cur_line_q), cur_col_q);
    wr_data    = key_char;

    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          case (key_cmd_e'(key_cmd))
            CMD_CHAR: begin
              wr_en = 1'b1;
              if (cur_col_q == LAST_COL) begin
                cur_col_d = '0;
                if (cur_line_q == LAST_LINE) begin
                  // Wrapping off the bottom: scroll, blank the new last line
                  top_d     = top_next;
                  clr_cnt_d = '0;
                  state_d   = ST_CLR_LINE;
                end else begin
                  cur_line_d = cur_line_q + LW'(1);
                  update_d   = 1'b1;
                end
              end else begin
                cur_col_d = cur_col_q + CW'(1);
                update_d  = 1'b1;
              end
            end
            CMD_BACKSPACE: begin
              // Home position has nothing to erase
              if (cur_line_q != '0 || cur_col_q != '0) begin
                wr_en    = 1'b1;
                wr_data  = BLANK;
                update_d = 1'b1;
                if (cur_col_q == '0) begin
                  cur_line_d = cur_line_q - LW'(1);
                  cur_col_d  = LAST_COL;
                  wr_addr    = cell_addr(phys_row(top_q, cur_line_q - LW'(1)), LAST_COL);
                end else begin
                  cur_col_d  = cur_col_q - CW'(1);
                  wr_addr    = cell_addr(phys_row(top_q, cur_line_q), cur_col_q - CW'(1));
                end
              end
            end
            CMD_ENTER: begin
              cur_col_d = '0;
              if (cur_line_q == LAST_LINE) begin
                top_d     = top_next;
                clr_cnt_d = '0;
                state_d   = ST_CLR_LINE;
              end else begin
                cur_line_d = cur_line_q + LW'(1);
                update_d   = 1'b1;
              end
            end
            CMD_CLEAR: begin
              cur_line_d = '0;
              cur_col_d  = '0;
              top_d      = '0;
              clr_cnt_d  = '0;
              state_d    = ST_CLR_ALL;
            end
          endcase
        end
      end
      ST_CLR_LINE: begin
        // The old top row has become the bottom logical line
        wr_en   = 1'b1;
        wr_data = BLANK;
        wr_addr = cell_addr(phys_row(top_q, LAST_LINE), clr_cnt_q[CW-1:0]);
        if (clr_cnt_q == LAST_LCNT) begin
          state_d  = ST_IDLE;
          update_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      ST_CLR_ALL: begin
        wr_en   = 1'b1;
        wr_data = BLANK;
        wr_addr = clr_cnt_q;
        if (clr_cnt_q == LAST_CELL) begin
          state_d  = ST_IDLE;
          update_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_CLR_ALL;
      end
    endcase
  end

  // Controller registers; reset parks in a full clear from cell 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_CLR_ALL;
      top_q      <= '0;
      cur_line_q <= '0;
      cur_col_q  <= '0;
      clr_cnt_q  <= '0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      cur_line_q <= cur_line_d;
      cur_col_q  <= cur_col_d;
      clr_cnt_q  <= clr_cnt_d;
      update_q   <= update_d;
    end
  end

  char_ram #(
    .DEPTH (LINES * COLS),
    .WIDTH (CHAR_W),
    .AW    (AW)
  ) u_char_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en & rst),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign key_ready = (state_q == ST_IDLE);
  assign cur_line  = cur_line_q;
  assign cur_col   = cur_col_q;
  assign update    = update_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_text_buffer
// Description : Self-checking bench for lcd_text_buffer: directed table,
//               hand sequences for scroll/backspace/reset-in-clear, and
//               random key events against a logical screen model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_text_buffer;
  import lcd_pkg::*;

  localparam int LINES  = 2;
  localparam int COLS   = 16;
  localparam int CHAR_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_cmd = 2'd0;
  logic [7:0] key_char = 8'h00;
  logic       key_ready;
  logic [0:0] rd_line = '0;
  logic [3:0] rd_col = '0;
  logic [7:0] rd_data;
  logic [0:0] cur_line;
  logic [3:0] cur_col;
  logic       update;

  int total = 0;
  int bad   = 0;

  // Logical screen model: line 0 is always the top visible line
  logic [7:0] scr [LINES][COLS];
  int ml = 0;
  int mc = 0;

  lcd_text_buffer #(.LINES(LINES), .COLS(COLS), .CHAR_W(CHAR_W)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_cmd(key_cmd),
    .key_char(key_char), .key_ready(key_ready), .rd_line(rd_line),
    .rd_col(rd_col), .rd_data(rd_data), .cur_line(cur_line),
    .cur_col(cur_col), .update(update)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_blank();
    for (int l = 0; l < LINES; l++)
      for (int c = 0; c < COLS; c++)
        scr[l][c] = 8'h20;
  endtask

  task automatic model_scroll();
    for (int l = 0; l < LINES - 1; l++)
      for (int c = 0; c < COLS; c++)
        scr[l][c] = scr[l+1][c];
    for (int c = 0; c < COLS; c++)
      scr[LINES-1][c] = 8'h20;
  endtask

  // Screen rules in logical terms; returns expected busy cycles and update
  task automatic model_apply(input logic [1:0] cmd, input logic [7:0] ch,
                             output int busy, output int upd);
    busy = 0;
    upd  = 1;
    if (cmd == CMD_CHAR) begin
      scr[ml][mc] = ch;
      if (mc == COLS - 1) begin
        mc = 0;
        if (ml == LINES - 1) begin
          model_scroll();
          busy = COLS;
        end else ml++;
      end else mc++;
    end else if (cmd == CMD_BACKSPACE) begin
      if (ml == 0 && mc == 0) upd = 0;
      else begin
        if (mc == 0) begin ml--; mc = COLS - 1; end
        else mc--;
        scr[ml][mc] = 8'h20;
      end
    end else if (cmd == CMD_ENTER) begin
      mc = 0;
      if (ml == LINES - 1) begin
        model_scroll();
        busy = COLS;
      end else ml++;
    end else begin
      model_blank();
      ml = 0;
      mc = 0;
      busy = LINES * COLS;
    end
  endtask

  // Offer one event; optionally wait out the busy period and check it
  task automatic send(input logic [1:0] cmd, input logic [7:0] ch, input bit wait_done,
                      output int act_busy, output int act_upd);
    int w = 0;
    int eb, eu, first;
    while (!key_ready && w < 500) begin step(); w++; end
    if (!key_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got key_ready=0 expected 1");
    end
    model_apply(cmd, ch, eb, eu);
    key_valid = 1'b1; key_cmd = cmd; key_char = ch;
    step();
    key_valid = 1'b0;
    first = int'(update);
    act_busy = 0;
    act_upd  = first;
    if (wait_done) begin
      while (!key_ready && act_busy < 500) begin step(); act_busy++; end
      act_upd = int'(update);
      if (eb > 0) check("early_update", first, 0);
      check("busy_cycles", act_busy, eb);
      check("update_pulse", act_upd, eu);
      check("cursor_line", cur_line, ml);
      check("cursor_col", cur_col, mc);
    end
  endtask

  task automatic read_cell(input int l, input int c, output logic [7:0] d);
    rd_line = l[0:0];
    rd_col  = c[3:0];
    step();
    d = rd_data;
  endtask

  task automatic check_screen();
    logic [7:0] d;
    for (int l = 0; l < LINES; l++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(l, c, d);
        check($sformatf("cell_%0d_%0d", l, c), d, scr[l][c]);
      end
  endtask

  // Hold reset, check reset outputs, release and time the clear
  task automatic do_reset();
    int n = 0;
    rst = 1'b0;
    repeat (3) step();
    check("rst_key_ready", key_ready, 0);
    check("rst_update", update, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_cur_line", cur_line, 0);
    check("rst_cur_col", cur_col, 0);
    rst = 1'b1;
    while (!key_ready && n < 200) begin step(); n++; end
    check("ready_after_reset", n, LINES * COLS);
    model_blank();
    ml = 0;
    mc = 0;
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] ch;
    int line;
    int col;
    int busy;
    int upd;
  } vec_t;

  vec_t tv [10];

  initial begin
    int b, u, r;
    logic [7:0] d;
    logic [1:0] cmd;

    tv[0] = '{CMD_CHAR,      8'h41, 0, 1,  0, 1};
    tv[1] = '{CMD_CHAR,      8'h42, 0, 2,  0, 1};
    tv[2] = '{CMD_BACKSPACE, 8'h00, 0, 1,  0, 1};
    tv[3] = '{CMD_BACKSPACE, 8'h00, 0, 0,  0, 1};
    tv[4] = '{CMD_BACKSPACE, 8'h00, 0, 0,  0, 0};
    tv[5] = '{CMD_ENTER,     8'h00, 1, 0,  0, 1};
    tv[6] = '{CMD_BACKSPACE, 8'h00, 0, 15, 0, 1};
    tv[7] = '{CMD_ENTER,     8'h00, 1, 0,  0, 1};
    tv[8] = '{CMD_ENTER,     8'h00, 1, 0, 16, 1};
    tv[9] = '{CMD_CLEAR,     8'h00, 0, 0, 32, 1};

    model_blank();
    do_reset();
    check_screen();

    // Two characters on a fresh screen
    send(CMD_CHAR, 8'h41, 1'b1, b, u);
    check("A_update", u, 1);
    send(CMD_CHAR, 8'h42, 1'b1, b, u);
    check("B_update", u, 1);
    read_cell(0, 0, d); check("AB_cell00", d, 8'h41);
    read_cell(0, 1, d); check("AB_cell01", d, 8'h42);
    check("AB_cur_line", cur_line, 0);
    check("AB_cur_col", cur_col, 2);
    send(CMD_CLEAR, 8'h00, 1'b1, b, u);

    // Directed table from a blank screen at home
    for (int i = 0; i < 10; i++) begin
      send(tv[i].cmd, tv[i].ch, 1'b1, b, u);
      check($sformatf("tv%0d_line", i), cur_line, tv[i].line);
      check($sformatf("tv%0d_col", i), cur_col, tv[i].col);
      check($sformatf("tv%0d_busy", i), b, tv[i].busy);
      check($sformatf("tv%0d_upd", i), u, tv[i].upd);
    end
    check_screen();

    // Line wrap after 17 characters, then scroll on the 32nd
    for (int n = 0; n < 17; n++) send(CMD_CHAR, 8'h30 + 8'(n), 1'b1, b, u);
    read_cell(1, 0, d); check("wrap_cell10", d, 8'h40);
    check("wrap_cur_line", cur_line, 1);
    check("wrap_cur_col", cur_col, 1);
    for (int n = 17; n < 32; n++) send(CMD_CHAR, 8'h30 + 8'(n), 1'b1, b, u);
    check("scroll_busy", b, 16);
    send(CMD_CHAR, 8'h5A, 1'b1, b, u);
    check("scroll_cur_line", cur_line, 1);
    check("scroll_cur_col", cur_col, 1);
    read_cell(0, 0, d);  check("scroll_cell00", d, 8'h40);
    read_cell(0, 15, d); check("scroll_cell015", d, 8'h4F);
    read_cell(1, 0, d);  check("scroll_cell10", d, 8'h5A);
    read_cell(1, 1, d);  check("scroll_cell11", d, 8'h20);
    check_screen();

    // Backspace across a line boundary and at home
    send(CMD_BACKSPACE, 8'h00, 1'b1, b, u);
    send(CMD_BACKSPACE, 8'h00, 1'b1, b, u);
    check("bs_cur_line", cur_line, 0);
    check("bs_cur_col", cur_col, 15);
    read_cell(0, 15, d); check("bs_cell015", d, 8'h20);
    send(CMD_CLEAR, 8'h00, 1'b1, b, u);
    send(CMD_BACKSPACE, 8'h00, 1'b1, b, u);
    check("bs_home_upd", u, 0);
    check("bs_home_col", cur_col, 0);

    // Reset in the middle of a clear restarts it from cell 0
    send(CMD_CHAR, 8'h61, 1'b1, b, u);
    send(CMD_CHAR, 8'h62, 1'b1, b, u);
    send(CMD_CLEAR, 8'h00, 1'b0, b, u);
    repeat (9) step();
    do_reset();
    check_screen();

    // Random events against the model
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      cmd = CMD_CHAR;
      else if (r < 78) cmd = CMD_BACKSPACE;
      else if (r < 96) cmd = CMD_ENTER;
      else             cmd = CMD_CLEAR;
      send(cmd, 8'($urandom_range(33, 126)), 1'b1, b, u);
      if (i % 4 == 3) check_screen();
    end
    check_screen();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
